// File: rtl/temp_poll_ctrl_pkg.sv
// temp_poll_ctrl shared definitions: FSM states, sensor word layout,
// the I2C slave address and the word-to-temperature helper.
package temp_poll_ctrl_pkg;

  localparam int TMP_LSB_SHIFT = 4;
  localparam int TMP_WIDTH     = 12;

  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h48;

  typedef logic signed [TMP_WIDTH-1:0] temp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DATA,
    ST_PROCESS
  } state_e;

  // Sensor returns a left-justified 12-bit two's complement value.
  function automatic temp_t word_to_temp(
    input logic [15:0] w
  );
    return temp_t'(w >> TMP_LSB_SHIFT);
  endfunction

endpackage

// File: rtl/temp_poll_ctrl_if.sv
// Handshake between temp_poll_ctrl (master) and the I2C engine (slave).
// start: 1-cycle request; busy/valid/data: engine status and result word.
interface temp_poll_ctrl_if;

  logic        start;
  logic        busy;
  logic        valid;
  logic [15:0] data;

  modport master (
    output start,
    input  busy,
    input  valid,
    input  data
  );

  modport slave (
    input  start,
    output busy,
    output valid,
    output data
  );

endinterface

// File: rtl/temp_poll_ctrl_poll_tick_gen.sv
// Poll period divider: counts 0..POLL_DIV-1, tick on terminal count.
// Ports: clk, reset (async high), clr (hold at 0), tick (1-cycle out).
module poll_tick_gen #(
  parameter int POLL_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(POLL_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CW'(POLL_DIV - 1));
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/temp_poll_ctrl.sv
// Temperature poller: starts I2C reads on a fixed grid, captures the
// word, keeps raw/IIR-avg/min/max, sample count and a sticky timeout.
// Ports: clk, reset (async high), enable, err_clr, i2c (master modport),
// temp_raw/avg/min/max, sample_valid, sample_cnt, timeout_err.
module temp_poll_ctrl
  import temp_poll_ctrl_pkg::*;
#(
  parameter int POLL_DIV    = 100_000_000,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int AVG_SHIFT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             err_clr,
  temp_poll_ctrl_if.master i2c,
  output temp_t            temp_raw,
  output temp_t            temp_avg,
  output temp_t            temp_min,
  output temp_t            temp_max,
  output logic             sample_valid,
  output logic [15:0]      sample_cnt,
  output logic             timeout_err
);

  localparam int AW = TMP_WIDTH + AVG_SHIFT + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_e state_q, state_d, end_st;

  logic tick, tick_clr;
  logic in_xfer, timeout, to_exp;
  logic pend_q, pend_d;

  logic [TW-1:0] to_cnt_q, to_cnt_d;

  temp_t raw_q, raw_d;
  temp_t traw_q, traw_d;
  temp_t avg_q, avg_d;
  temp_t min_q, min_d;
  temp_t max_q, max_d;

  logic signed [AW-1:0] acc_q, acc_d, raw_ext;

  logic        first_q, first_d;
  logic        sv_q, sv_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  assign tick_clr = (state_q == ST_IDLE);

  poll_tick_gen #(
    .POLL_DIV(POLL_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign in_xfer = (state_q == ST_ISSUE)
                || (state_q == ST_WAIT_BUSY)
                || (state_q == ST_WAIT_DATA)
                || (state_q == ST_PROCESS);

  assign to_exp = (to_cnt_q >= TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Where a finished (or timed-out) transaction goes next; a tick
  // that elapsed while the master was busy fires ISSUE right away.
  always_comb begin
    end_st = ST_WAIT_TICK;
    if (!enable) begin
      end_st = ST_IDLE;
    end else if (pend_q || tick) begin
      end_st = ST_ISSUE;
    end
  end

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_ISSUE;
      end
      ST_WAIT_TICK: begin
        if (!enable)   state_d = ST_IDLE;
        else if (tick) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i2c.busy)    state_d = ST_WAIT_DATA;
        else if (to_exp) timeout = 1'b1;
      end
      ST_WAIT_DATA: begin
        if (i2c.valid)   state_d = ST_PROCESS;
        else if (to_exp) timeout = 1'b1;
      end
      ST_PROCESS: begin
        state_d = end_st;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (timeout) state_d = end_st;
  end

  always_comb begin
    i2c.start = (state_q == ST_ISSUE);
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    pend_d   = pend_q;
    raw_d    = raw_q;
    traw_d   = traw_q;
    avg_d    = avg_q;
    min_d    = min_q;
    max_d    = max_q;
    acc_d    = acc_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    sv_d     = (state_q == ST_PROCESS);
    raw_ext  = {{(AW-TMP_WIDTH){raw_q[TMP_WIDTH-1]}}, raw_q};

    unique case (1'b1)
      (state_q == ST_ISSUE): to_cnt_d = '0;
      (state_q == ST_WAIT_BUSY),
      (state_q == ST_WAIT_DATA): begin
        if (!to_exp) to_cnt_d = to_cnt_q + 1'b1;
      end
      default: ;
    endcase

    if (in_xfer && tick) pend_d = 1'b1;
    if (!in_xfer || timeout || state_q == ST_PROCESS) begin
      pend_d = 1'b0;
    end

    if (state_q == ST_WAIT_DATA && i2c.valid) begin
      raw_d = word_to_temp(i2c.data);
    end

    if (state_q == ST_PROCESS) begin
      traw_d  = raw_q;
      first_d = 1'b0;
      if (first_q) begin
        acc_d = raw_ext <<< AVG_SHIFT;
        min_d = raw_q;
        max_d = raw_q;
      end else begin
        acc_d = acc_q + raw_ext - (acc_q >>> AVG_SHIFT);
        min_d = (raw_q < min_q) ? raw_q : min_q;
        max_d = (raw_q > max_q) ? raw_q : max_q;
      end
      avg_d = temp_t'(acc_d >>> AVG_SHIFT);
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (timeout) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      pend_q   <= 1'b0;
      raw_q    <= '0;
      traw_q   <= '0;
      avg_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      acc_q    <= '0;
      first_q  <= 1'b1;
      cnt_q    <= '0;
      sv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      pend_q   <= pend_d;
      raw_q    <= raw_d;
      traw_q   <= traw_d;
      avg_q    <= avg_d;
      min_q    <= min_d;
      max_q    <= max_d;
      acc_q    <= acc_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      sv_q     <= sv_d;
      err_q    <= err_d;
    end
  end

  assign temp_raw     = traw_q;
  assign temp_avg     = avg_q;
  assign temp_min     = min_q;
  assign temp_max     = max_q;
  assign sample_valid = sv_q;
  assign sample_cnt   = cnt_q;
  assign timeout_err  = err_q;

endmodule

// File: tb/tb_temp_poll_ctrl.sv
// Bench for temp_poll_ctrl: directed + randomized transactions from an
// inline master model, checked against a sample-history reference.
module tb_temp_poll_ctrl;

  localparam int PD = 100;
  localparam int TO = 50;
  localparam int AS = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic err_clr = 1'b0;

  temp_poll_ctrl_if bus();

  logic [11:0] temp_raw, temp_avg, temp_min, temp_max;
  logic        sample_valid, timeout_err;
  logic [15:0] sample_cnt;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int last_start = 0;

  int samples[$];
  int m_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  temp_poll_ctrl #(
    .POLL_DIV(PD),
    .TIMEOUT_CYC(TO),
    .AVG_SHIFT(AS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .err_clr(err_clr),
    .i2c(bus),
    .temp_raw(temp_raw),
    .temp_avg(temp_avg),
    .temp_min(temp_min),
    .temp_max(temp_max),
    .sample_valid(sample_valid),
    .sample_cnt(sample_cnt),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    samples.delete();
    m_acc = 0;
  endfunction

  function automatic void m_add(input int t);
    if (samples.size() == 0) m_acc = t * (1 << AS);
    else m_acc = m_acc + t - (m_acc >>> AS);
    samples.push_back(t);
  endfunction

  task automatic chk_stats();
    logic [11:0] e_raw, e_avg, e_min, e_max;
    int mn, mx, n;
    e_raw = '0; e_avg = '0; e_min = '0; e_max = '0;
    n = samples.size();
    if (n > 0) begin
      mn = samples[0];
      mx = samples[0];
      foreach (samples[i]) begin
        if (samples[i] < mn) mn = samples[i];
        if (samples[i] > mx) mx = samples[i];
      end
      e_raw = 12'(samples[n-1]);
      e_avg = 12'(m_acc >>> AS);
      e_min = 12'(mn);
      e_max = 12'(mx);
    end
    chk("temp_raw", temp_raw, e_raw);
    chk("temp_avg", temp_avg, e_avg);
    chk("temp_min", temp_min, e_min);
    chk("temp_max", temp_max, e_max);
    chk("sample_cnt", sample_cnt, (n > 65535) ? 65535 : n);
  endtask

  task automatic wait_start(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.start === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk("start_seen", 32'(t >= 0), 1);
  endtask

  task automatic xfer(input int tmp, input int b, input int v,
                      input int exp_t, input bit drop_en);
    int t;
    logic [15:0] w;
    w = {12'(tmp), 4'($urandom)};
    wait_start(PD + 10, t);
    chk("start_time", t, exp_t);
    last_start = t;
    @(negedge clk);
    chk("start_width", bus.start, 0);
    repeat (b - 1) @(negedge clk);
    bus.busy = 1'b1;
    @(negedge clk);
    if (drop_en) enable = 1'b0;
    repeat (v - 1) @(negedge clk);
    bus.data = w;
    bus.valid = 1'b1;
    @(negedge clk);
    bus.valid = 1'b0;
    bus.busy = 1'b0;
    bus.data = 16'($urandom);
    chk("sv_early", sample_valid, 0);
    @(negedge clk);
    chk("sv_pulse", sample_valid, 1);
    m_add(tmp);
    chk_stats();
    @(negedge clk);
    chk("sv_width", sample_valid, 0);
  endtask

  task automatic tmo(input int exp_t, input bit clr_same);
    int t, rise;
    bit saw_sv;
    rise = -1;
    saw_sv = 1'b0;
    wait_start(PD + 10, t);
    chk("tmo_start_time", t, exp_t);
    last_start = t;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      err_clr = (clr_same && cyc == t + TO);
      if (sample_valid) saw_sv = 1'b1;
      if (timeout_err && rise < 0) rise = cyc;
    end
    err_clr = 1'b0;
    chk("tmo_rise", rise, t + 1 + TO);
    chk("tmo_no_sv", 32'(saw_sv), 0);
    chk("tmo_sticky", timeout_err, 1);
    chk_stats();
  endtask

  initial begin
    int t, c0, ns;
    bus.busy = 1'b0;
    bus.valid = 1'b0;
    bus.data = '0;
    m_reset();

    repeat (3) @(negedge clk);
    chk("rst_start", bus.start, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_err", timeout_err, 0);
    chk_stats();

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", bus.start, 0);

    c0 = cyc;
    enable = 1'b1;
    xfer(12'h190, 2, 2, c0 + 1, 1'b0);
    xfer(-400, 1, 3, last_start + PD, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int tmp;
      tmp = (i == 0) ? -2048 :
            (i == 1) ? 2047 :
            int'($urandom_range(4095)) - 2048;
      xfer(tmp, int'($urandom_range(5, 1)),
           int'($urandom_range(5, 1)), last_start + PD, 1'b0);
    end

    tmo(last_start + PD, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);
    tmo(last_start + PD, 1'b1);
    xfer(int'($urandom_range(4095)) - 2048, 3, 2,
         last_start + PD, 1'b0);

    xfer(-7, 1, 3, last_start + PD, 1'b1);
    ns = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.start === 1'b1) ns++;
    end
    chk("no_start_disabled", ns, 0);

    c0 = cyc;
    enable = 1'b1;
    wait_start(10, t);
    chk("re_enable_start", t, c0 + 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_reset();
    chk("async_rst_err", timeout_err, 0);
    chk("async_rst_sv", sample_valid, 0);
    chk("async_rst_start", bus.start, 0);
    chk_stats();
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    xfer(-100, 2, 2, c0 + 1, 1'b0);
    xfer(300, 2, 4, last_start + PD, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
